// File: rtl/sipo_deser.sv
// sipo_deser: serial-in, parallel-out deserializer (receive side of the PISO
// serializer). Bits arrive one per qualified clock and are assembled into
// WIDTH-bit words, which are handed to a parallel consumer through a
// valid/ready output register with sticky overrun reporting.
//
// Optional build macro SIPO_PARITY_EN: each frame carries one extra
// even-parity bit after the data bits, and a parity_err output is added.
module sipo_deser #(
    parameter int WIDTH     = 4,  // data bits per word, 2..32
    parameter int MSB_FIRST = 1   // 1: first bit -> dout[WIDTH-1]; 0: -> dout[0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
`ifdef SIPO_PARITY_EN
    output logic             parity_err,
`endif
    input  logic             clr_ovr
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             word_perr;
`ifdef SIPO_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    // Place one new bit into the shift register in the configured bit order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic             b);
        if (MSB_FIRST != 0) begin
            return {cur[WIDTH-2:0], b};
        end else begin
            return {b, cur[WIDTH-1:1]};
        end
    endfunction

    // Receive FSM: bit capture, bit counting, resync and word completion.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        count_d   = count_q;
        sreg_d    = sreg_q;
        word_done = 1'b0;
`ifdef SIPO_PARITY_EN
        // The parity bit is checked but never shifted into the data word.
        word      = sreg_q;
        word_perr = ^{sreg_q, sin};
`else
        word      = shift_in(sreg_q, sin);
        word_perr = 1'b0;
`endif
        if (frame_start) begin
            // Resync: the partial word is thrown away.
            if (sin_valid) begin
                sreg_d  = shift_in('0, sin);
                count_d = CW'(1);
                state_d = RECV;
            end else begin
                count_d = '0;
                state_d = IDLE;
            end
        end else if (sin_valid) begin
            unique case (state_q)
                IDLE: begin
                    sreg_d  = shift_in(sreg_q, sin);
                    count_d = CW'(1);
                    state_d = RECV;
                end
                RECV: begin
                    if (count_q == LAST_IDX) begin
                        word_done = 1'b1;
                        count_d   = '0;
                        state_d   = IDLE;
`ifndef SIPO_PARITY_EN
                        sreg_d    = shift_in(sreg_q, sin);
`endif
                    end else begin
                        sreg_d  = shift_in(sreg_q, sin);
                        count_d = count_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Output register: load on completion, drop and flag overrun when stalled.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
`ifdef SIPO_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        busy_d       = (count_d != '0);
        // Clear first so a same-cycle overrun event below wins.
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end
        if (word_done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                parity_err_d = word_perr;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset that overrides every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            sreg_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            sreg_q       <= sreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
`ifdef SIPO_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
`ifdef SIPO_PARITY_EN
    assign parity_err = parity_err_q;
`else
    // Parity result only exists in the parity build.
    logic unused_perr;
    assign unused_perr = word_perr;
`endif

endmodule
